data_mem_access: RTL and testbench

Memory-stage responder for the load/store control signals generated by the instruction decoder. It accepts one load or store per request (`Enable_signal`, `load_instr`, `Size_enable`), drives a word-wide data memory port with byte enables and a ready handshake, and returns zero-extended load data. It stalls the pipeline until the access completes, flags misaligned word accesses, and flags memory timeouts.

---
 rtl/data_mem_access.sv | 121 ++++++++++++
 tb/tb_data_mem_access.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_access.sv
// Memory-stage load/store responder: drives a word-wide memory port with byte enables,
// stalls the pipeline until the access retires, and flags misalignment and memory timeouts.
module data_mem_access #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Enable_signal,
  input  logic        load_instr,
  input  logic        Size_enable,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        done,
  output logic        align_err,
  output logic        timeout_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_load;
  logic          r_byte;
  logic [1:0]    r_lane;
  logic [7:0]    w_lane_byte;

  always_comb begin
    w_lane_byte = mem_rdata[7:0];
    case (r_lane)
      2'd1:    w_lane_byte = mem_rdata[15:8];
      2'd2:    w_lane_byte = mem_rdata[23:16];
      2'd3:    w_lane_byte = mem_rdata[31:24];
      default: w_lane_byte = mem_rdata[7:0];
    endcase
  end

  // Combinational so the pipeline holds in the very cycle a request is presented.
  assign stall = ((r_state == S_IDLE) && Enable_signal) || (r_state == S_ACCESS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_load      <= 1'b0;
      r_byte      <= 1'b0;
      r_lane      <= 2'd0;
      load_data   <= '0;
      done        <= 1'b0;
      align_err   <= 1'b0;
      timeout_err <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= '0;
      mem_wdata   <= '0;
    end else begin
      done        <= 1'b0;
      align_err   <= 1'b0;
      timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Enable_signal) begin
            r_load <= load_instr;
            r_byte <= Size_enable;
            r_lane <= address[1:0];
            if (!Size_enable && (address[1:0] != 2'b00)) begin
              r_state   <= S_DONE;
              done      <= 1'b1;
              align_err <= 1'b1;
            end else begin
              r_state  <= S_ACCESS;
              r_cnt    <= '0;
              mem_req  <= 1'b1;
              mem_we   <= !load_instr;
              mem_addr <= address[31:2];
              if (Size_enable) begin
                mem_be    <= 4'b0001 << address[1:0];
                mem_wdata <= {4{store_data[7:0]}};
              end else begin
                mem_be    <= 4'b1111;
                mem_wdata <= store_data;
              end
            end
          end
        end
        S_ACCESS: begin
          // Ready wins over the timeout on the final wait cycle.
          if (mem_ready || (r_cnt == CW'(TIMEOUT - 1))) begin
            r_state     <= S_DONE;
            done        <= 1'b1;
            timeout_err <= !mem_ready;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_be      <= '0;
            mem_wdata   <= '0;
            if (mem_ready && r_load) begin
              load_data <= r_byte ? {24'b0, w_lane_byte} : mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_access.sv
// Randomized scoreboard bench for data_mem_access against a byte-array memory reference.
module tb_data_mem_access;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Enable_signal = 1'b0;
  logic        load_instr = 1'b0;
  logic        Size_enable = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] store_data = '0;
  logic [31:0] load_data;
  logic        stall, done, align_err, timeout_err;
  logic        mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  data_mem_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .Enable_signal(Enable_signal), .load_instr(load_instr),
    .Size_enable(Size_enable), .address(address), .store_data(store_data),
    .load_data(load_data), .stall(stall), .done(done), .align_err(align_err),
    .timeout_err(timeout_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        ae;
    logic        te;
    logic [31:0] ld;
    int          lat;
  } exp_t;

  typedef struct {
    int          l;
    logic        we;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } acc_t;

  exp_t        exp_q[$];
  acc_t        acc_q[$];
  logic [7:0]  ref_b [0:63];
  logic [31:0] mem_w [0:15];
  logic [31:0] exp_ld = '0;
  int          issue_cyc = 0;

  // Monitor: retire checks on every done pulse.
  int   scnt = 0;
  exp_t me;
  always @(negedge clk) begin
    if (!rst_n) begin
      scnt = 0;
    end else begin
      if (stall) scnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          me = exp_q.pop_front();
          chk("align_err", {31'b0, align_err}, {31'b0, me.ae});
          chk("timeout_err", {31'b0, timeout_err}, {31'b0, me.te});
          chk("load_data", load_data, me.ld);
          chk("latency", cyc - issue_cyc, me.lat);
          chk("stall_cycles", scnt, me.lat);
        end
        scnt = 0;
      end else if (align_err || timeout_err) begin
        chk("err_without_done", {30'b0, align_err, timeout_err}, 32'd0);
      end
    end
  end

  // Memory responder: checks the request fields each ACCESS cycle and answers after the planned wait.
  bit   busy = 0;
  bit   a_ok = 0;
  int   w = 0;
  int   rc = 0;
  acc_t ma;
  always @(negedge clk) begin
    if (mem_req) begin
      if (!busy) begin
        busy = 1;
        w    = 0;
        rc   = 0;
        if (acc_q.size() == 0) begin
          chk("unexpected_mem_req", 32'd1, 32'd0);
          a_ok = 0;
          ma.l = 0;
        end else begin
          ma   = acc_q.pop_front();
          a_ok = 1;
        end
      end else begin
        w++;
      end
      rc++;
      if (a_ok) begin
        chk("mem_we", {31'b0, mem_we}, {31'b0, ma.we});
        chk("mem_addr", {2'b0, mem_addr}, {2'b0, ma.addr});
        chk("mem_be", {28'b0, mem_be}, {28'b0, ma.be});
        chk("mem_wdata", mem_wdata, ma.wd);
      end
      if (w == ma.l) begin
        mem_ready = 1'b1;
        mem_rdata = mem_w[mem_addr[3:0]];
        if (mem_we) begin
          for (int k = 0; k < 4; k++)
            if (mem_be[k]) mem_w[mem_addr[3:0]][8*k +: 8] = mem_wdata[8*k +: 8];
        end
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
    end else begin
      if (busy && rst_n && a_ok)
        chk("mem_req_cycles", rc, (ma.l < TO) ? ma.l + 1 : TO);
      busy      = 0;
      mem_ready = $urandom_range(0, 1);  // ready outside ACCESS must be ignored
      mem_rdata = $urandom;
    end
  end

  // Called right after a posedge; returns right after the posedge ending DONE.
  task automatic issue(input bit ld, input bit by, input logic [31:0] ad,
                       input logic [31:0] sd, input int L);
    exp_t e;
    acc_t a;
    int   base;
    base = {26'b0, ad[5:2], 2'b00};
    e.ae = 0;
    e.te = 0;
    if (!by && ad[1:0] != 2'b00) begin
      e.ae  = 1;
      e.lat = 1;
    end else begin
      a.l    = L;
      a.we   = !ld;
      a.addr = ad[31:2];
      a.be   = by ? (4'b0001 << ad[1:0]) : 4'b1111;
      a.wd   = by ? {4{sd[7:0]}} : sd;
      acc_q.push_back(a);
      if (L < TO) begin
        e.lat = L + 2;
        if (ld) begin
          if (by) exp_ld = {24'b0, ref_b[ad[5:0]]};
          else    exp_ld = {ref_b[base+3], ref_b[base+2], ref_b[base+1], ref_b[base]};
        end else if (by) begin
          ref_b[ad[5:0]] = sd[7:0];
        end else begin
          for (int k = 0; k < 4; k++) ref_b[base+k] = sd[8*k +: 8];
        end
      end else begin
        e.te  = 1;
        e.lat = TO + 1;
      end
    end
    e.ld = exp_ld;
    #2;
    Enable_signal = 1'b1;
    load_instr    = ld;
    Size_enable   = by;
    address       = ad;
    store_data    = sd;
    issue_cyc     = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
    Enable_signal = 1'b0;
    store_data    = $urandom;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      chk("done_wait_expired", 32'd0, 32'd1);
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_w[i] = $urandom;
      for (int k = 0; k < 4; k++) ref_b[4*i+k] = mem_w[i][8*k +: 8];
    end
    repeat (3) @(posedge clk);
    #2;
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_flags", {27'b0, stall, done, align_err, timeout_err, mem_req}, 32'd0);
    chk("rst_mem", {mem_we, mem_be, mem_addr[26:0]} | mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);

    // Directed cases from the block's intended use.
    issue(0, 0, 32'h0000_0010, 32'hDEAD_BEEF, 0);
    issue(1, 0, 32'h0000_0010, 32'h0, 0);
    issue(0, 0, 32'h0000_0010, 32'hAABB_CCDD, 1);
    issue(1, 1, 32'h0000_0013, 32'h0, 0);
    issue(0, 1, 32'h0000_0011, 32'h1234_565A, 2);
    issue(1, 0, 32'h0000_0006, 32'h0, 0);
    issue(1, 0, 32'h0000_0020, 32'h0, TO + 3);
    issue(1, 0, 32'h0000_0010, 32'h0, TO - 1);
    issue(0, 0, 32'h0000_0007, 32'h0BAD_0BAD, 0);
    issue(1, 0, 32'h0000_0010, 32'h0, 0);

    for (int t = 0; t < 150; t++) begin
      int L;
      L = ($urandom_range(0, 7) == 0) ? TO + 1 : int'($urandom_range(0, TO - 1));
      issue($urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom, L);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Reset in the middle of an ACCESS with two wait states behind it.
    #2;
    acc_q.push_back('{l: 50, we: 1'b0, addr: 30'h8, be: 4'hF, wd: 32'h0});
    Enable_signal = 1'b1;
    load_instr    = 1'b1;
    Size_enable   = 1'b0;
    address       = 32'h0000_0020;
    store_data    = 32'h0;
    @(posedge clk);
    #2;
    Enable_signal = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("pre_rst_mem_req", {31'b0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("arst_flags", {28'b0, stall, done, align_err, timeout_err}, 32'd0);
    chk("arst_load_data", load_data, 32'd0);
    chk("arst_mem", {mem_we, mem_be, mem_addr[26:0]} | mem_wdata, 32'd0);
    acc_q.delete();
    exp_q.delete();
    exp_ld = '0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    issue(1, 0, 32'h0000_0010, 32'h0, 1);
    issue(1, 1, 32'h0000_0012, 32'h0, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
